// File: rtl/dff_pkg.sv
// Shared constants and helpers for the elastic DFF pipeline.
package dff_pkg;
  localparam logic DFF_RST_VAL_DEFAULT = 1'b0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// One WIDTH-bit pipeline stage: valid bit plus data bank with async/sync reset.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_VAL_DEFAULT}}
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             sync_rst,
  input  logic             load_en,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      vld  <= 1'b0;
      data <= RST_VAL;
    end else if (sync_rst) begin
      vld  <= 1'b0;
      data <= RST_VAL;
    end else if (load_en) begin
      vld <= vld_in;
      // invalid words are never captured so the data bank does not toggle
      if (vld_in) data <= data_in;
    end
  end

endmodule

// File: rtl/dff_pipe_elastic.sv
// DEPTH-stage elastic register pipeline with valid/ready on both sides and bubble collapse.
module dff_pipe_elastic
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_VAL_DEFAULT}}
) (
  input  logic                      clk,
  input  logic                      async_rst_n,
  input  logic                      sync_rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            v, rdy, vin;
  logic [DEPTH-1:0][WIDTH-1:0] d, din;
  logic                        in_xfer, out_xfer;

  // Ready ripples from the output side: a stage advances if it is empty
  // or everything downstream of it can move.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      rdy[i] = acc;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_link
    if (g == 0) begin : g_head
      assign vin[g] = in_valid;
      assign din[g] = in_data;
    end else begin : g_body
      assign vin[g] = v[g-1];
      assign din[g] = d[g-1];
    end
  end

  dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage [DEPTH-1:0] (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .sync_rst   (sync_rst),
    .load_en    (rdy),
    .vld_in     (vin),
    .data_in    (din),
    .vld        (v),
    .data       (d)
  );

  assign in_ready  = rdy[0] & async_rst_n & ~sync_rst;
  assign out_valid = v[DEPTH-1] & ~sync_rst;
  assign out_data  = d[DEPTH-1];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)             count <= '0;
    else if (sync_rst)            count <= '0;
    else if (in_xfer & ~out_xfer) count <= count + CW'(1);
    else if (~in_xfer & out_xfer) count <= count - CW'(1);
  end

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Directed bench for dff_pipe_elastic: 8x3 instance plus a 1x1 skid instance.
module tb_dff_pipe_elastic;

  logic       clk = 1'b0;
  logic       async_rst_n;
  logic       sync_rst, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  logic       sync_rst_b, in_valid_b, in_data_b, out_ready_b;
  logic       in_ready_b, out_valid_b, out_data_b;
  logic [0:0] count_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dff_pipe_elastic #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u_dut (
    .clk(clk), .async_rst_n(async_rst_n), .sync_rst(sync_rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  dff_pipe_elastic #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_dut_b (
    .clk(clk), .async_rst_n(async_rst_n), .sync_rst(sync_rst_b),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
    .count(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  word;
    logic mv, mq, exp_rdy;
    async_rst_n = 1'b0; sync_rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    sync_rst_b = 1'b0; in_valid_b = 1'b0; in_data_b = 1'b0; out_ready_b = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'hA5);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    async_rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // async reset mid-stream
    tick();
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_valid = 1'b0; tick();
    chk("fill_count", count, 2);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_out_data", out_data, 8'h01);
    #2 async_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 8'hA5);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 0);
    #1 async_rst_n = 1'b1;
    #1;
    chk("arst_rel_in_ready", in_ready, 1);

    // streaming latency and throughput
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 8);
      in_data  = 8'h10 + 8'(k);
      tick();
      if (k >= 2 && k <= 9) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_data", out_data, 8'h10 + 8'(k - 2));
      end else begin
        chk("stream_idle", out_valid, 0);
      end
      if (k >= 2 && k <= 7) chk("stream_count", count, 3);
    end
    chk("stream_drained", count, 0);

    // backpressure / full
    out_ready = 1'b0;
    word = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", in_ready, (i < 3));
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(word);
      tick();
      if (i < 3) word++;
    end
    chk("full_count", count, 3);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_data", out_data, 8'h20);
    tick();
    chk("full_hold_data", out_data, 8'h20);
    chk("full_hold_count", count, 3);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = (word < 5);
      in_data  = 8'h20 + 8'(word);
      #1;
      if (j < 2) chk("full_pass_in_ready", in_ready, 1);
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 8'h20 + 8'(j));
      tick();
      if (word < 5) word++;
    end
    in_valid = 1'b0;
    tick();
    chk("drain_empty_valid", out_valid, 0);
    chk("drain_empty_count", count, 0);

    // bubble collapse under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h30; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'h31; tick();
    in_valid = 1'b0; tick(); tick();
    chk("bubble_count", count, 2);
    chk("bubble_in_ready", in_ready, 1);
    chk("bubble_out_data", out_data, 8'h30);

    // sync reset
    sync_rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    #1;
    chk("srst_in_ready", in_ready, 0);
    chk("srst_out_valid", out_valid, 0);
    tick();
    sync_rst = 1'b0; in_valid = 1'b0;
    chk("srst_count", count, 0);
    chk("srst_out_data", out_data, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      chk("srst_no_ff", out_valid, 0);
      tick();
    end

    // DEPTH=1 skid register with random backpressure
    mv = 1'b0; mq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid_b  = 1'b1;
      in_data_b   = 1'($urandom);
      out_ready_b = 1'($urandom);
      #1;
      exp_rdy = ~mv | out_ready_b;
      chk("b_in_ready", in_ready_b, exp_rdy);
      chk("b_out_valid", out_valid_b, mv);
      chk("b_count", count_b, mv);
      if (mv) chk("b_out_data", out_data_b, mq);
      if (mv & out_ready_b) mv = 1'b0;
      if (exp_rdy) begin
        mv = 1'b1;
        mq = in_data_b;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dff_pipe_elastic.md
Name: dff_pipe_elastic

Overview:
Parametrised successor to the single-bit sync/async-reset D flip-flop. It is a WIDTH-bit, DEPTH-stage register pipeline with a valid/ready handshake on both sides. Each stage is a reset-capable DFF bank with a valid bit, and bubbles collapse when the output stalls. It is the generic retiming/elastic buffer for the RISC-V SoC datapath, for example between fetch and decode or across long routes to peripherals.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1)
RST_VAL, 0, value loaded into every data register on async or sync reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
async_rst_n  input  1  asynchronous, active-low reset; clears the whole pipeline immediately
sync_rst  input  1  synchronous, active-high clear; takes effect at the next clk rising edge
in_valid  input  1  upstream data valid
in_data  input  WIDTH  upstream data
in_ready  output  1  pipeline can accept in_data this cycle
out_valid  output  1  out_data is valid
out_data  output  WIDTH  data from the last stage
out_ready  input  1  downstream accepts out_data this cycle
count  output  $clog2(DEPTH+1)  number of occupied stages (0..DEPTH)

Behaviour:
- Reset priority: async_rst_n=0 > sync_rst=1 > normal operation.
- async_rst_n low: all valid bits go to 0 and all data registers go to RST_VAL immediately, without waiting for a clock edge.
  - Outputs while reset is asserted: out_valid=0, out_data=RST_VAL, count=0, in_ready=0.
  - On deassertion, in_ready is 1 in the same cycle.
- sync_rst high:
  - in_ready=0 and out_valid=0 (combinationally gated), so no transfer occurs on either side.
  - At the next clk edge, all valid bits clear and all data registers load RST_VAL.
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i]. Advance rule for stage i:
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
  - rdy[i] = !v[i] | rdy[i+1]
  - in_ready = rdy[0]
  - This is a combinational ripple of DEPTH gates; that path is accepted by design.
- On each clk edge, when rdy[i] is 1:
  - Stage 0 loads v[0] <= in_valid and d[0] <= in_data.
  - Stage i>0 loads v[i] <= v[i-1] and d[i] <= d[i-1].
  - Data registers load only when the incoming valid is 1; otherwise they hold. This is a power rule, so invalid data is never captured.
- When rdy[i] is 0, stage i holds both its valid and its data.
- Transfers: an input transfer happens when in_valid & in_ready; an output transfer happens when out_valid & out_ready.
- Latency: a word accepted at edge N presents out_valid=1 after edge N+DEPTH-1, provided there are no stalls. Throughput is 1 word/cycle when out_ready stays 1.
- Bubbles: an empty stage always accepts, so gaps collapse while the output is stalled. Up to DEPTH words can be buffered.
- Full (count=DEPTH, out_ready=0): in_ready=0 and all data holds stable.
- Full with out_ready=1: in_ready=1, and an input transfer and an output transfer occur in the same cycle. count stays at DEPTH.
- count: registered. It increments on an input transfer, decrements on an output transfer, and is unchanged when both happen. It clears on either reset and never exceeds DEPTH or drops below 0.
- Order: word order is strictly preserved. No word is ever dropped or duplicated.
- out_data is the registered d[DEPTH-1]; there is no combinational path from in_data to out_data.
- DEPTH=1: degenerates to a single-entry skid register with in_ready = !v[0] | out_ready.

Decomposition:
- Shared package dff_pkg holds the DFF_RST_VAL_DEFAULT constant and the count-width function cnt_w(DEPTH)=$clog2(DEPTH+1).
- Natural sub-module: dff_pipe_stage, one WIDTH-bit stage with valid, load enable, async_rst_n, sync_rst and RST_VAL. The top instantiates it DEPTH times in a generate loop and adds the ready chain and the counter.

Test Plan:
- Async reset mid-stream: WIDTH=8, DEPTH=3, RST_VAL=8'hA5; fill with 8'h01, 8'h02; pulse async_rst_n low off-edge (e.g. t=23ns) -> out_valid=0, out_data=8'hA5, count=0 immediately without a clk edge; in_ready=1 after release.
- Streaming latency: out_ready=1; send 8'h10..8'h17 on consecutive cycles -> 8'h10 has out_valid=1 after the 3rd edge; 8 words emerge back-to-back in order; count holds 3 in steady state.
- Backpressure/full: out_ready=0; offer 8'h20..8'h24 -> only 8'h20..8'h22 accepted; in_ready=0 with count=3; raise out_ready -> 8'h20, 8'h21, 8'h22, 8'h23, 8'h24 delivered, no loss or duplication.
- Bubble collapse: send 8'h30, idle 2 cycles, send 8'h31, with out_ready=0 -> both end in stages 2 and 1, count=2, in_ready=1.
- Sync reset: with count=2, assert sync_rst for 1 cycle alongside in_valid=1 and 8'hFF -> in_ready=0 and out_valid=0 during the cycle; after the edge count=0, out_data=8'hA5, and 8'hFF is never output.
- DEPTH=1, WIDTH=1: toggle out_ready randomly with continuous in_valid -> the output sequence equals the accepted input sequence and count stays in {0,1}.
